cmp_seq32: RTL and testbench
============================

CMP_SEQ32 -- requirements
Module: cmp_seq32

Interface
REQ-001 SHALL have parameter SLICE_W, default 4, bits compared per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port data_operandA  input  32  first operand.
REQ-007 SHALL have port data_operandB  input  32  second operand.
REQ-008 SHALL have port cmp_unsigned  input  1  1 = unsigned compare, 0 = two's-complement signed; sampled with operands.
REQ-009 SHALL have port out_valid  output  1  result flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port isNotEqual  output  1  1 when A != B.
REQ-012 SHALL have port isLessThan  output  1  1 when A < B under the captured mode.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; no acceptance in SCAN or DONE (no bypass).
REQ-015 IDLE: in_valid=1 at an edge SHALL capture A, B, mode, set slice index to top slice (bits 31..32-SLICE_W), and enter SCAN.
REQ-016 On capture in signed mode, bit 31 of both captured operands SHALL be inverted so the scan is an unsigned magnitude compare; unsigned mode captures unchanged.
REQ-017 SCAN: each cycle SHALL compare the current SLICE_W-bit slice of A and B, MSB slice first.
REQ-018 SCAN, slices differ: isNotEqual<=1, isLessThan<=(A slice < B slice), enter DONE (early termination).
REQ-019 SCAN, slices equal, not last slice: index decrements by one slice, stay in SCAN.
REQ-020 SCAN, slices equal, last slice (bits SLICE_W-1..0): isNotEqual<=0, isLessThan<=0, enter DONE.
REQ-021 Latency: with capture at edge E0 and k slices examined (1..32/SLICE_W), out_valid SHALL rise after edge E0+k.
REQ-022 DONE: out_valid=1; flags stable; out_ready=1 at an edge returns to IDLE; out_ready=0 holds DONE indefinitely.
REQ-023 out_valid SHALL be 0 in IDLE and SCAN.
REQ-024 isNotEqual/isLessThan SHALL change only on a SCAN resolution edge or reset; values hold through IDLE until next resolution.
REQ-025 in_valid/operand changes during SCAN or DONE SHALL have no effect.
REQ-026 in_valid and out_ready both high in DONE SHALL not accept; acceptance occurs earliest the edge after return to IDLE.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, out_valid=0, isNotEqual=0, isLessThan=0, slice index to top, captured operands to 0.
REQ-028 reset asserted mid-SCAN or in DONE SHALL discard the in-flight comparison; no result is ever presented for it.
REQ-029 First acceptance after reset_n deassertion SHALL occur at the first rising edge with in_valid=1.

Verification
REQ-030 SLICE_W=4, A=B=0x12345678, signed -> 8 cycles to out_valid; isNotEqual=0, isLessThan=0.
REQ-031 SLICE_W=4, A=0x80000000, B=0x00000001, signed -> resolves at slice 1 (1 cycle); isNotEqual=1, isLessThan=1; same operands unsigned -> isNotEqual=1, isLessThan=0.
REQ-032 SLICE_W=4, A=0x00000010, B=0x00000011 unsigned -> resolves on last slice (8 cycles); isNotEqual=1, isLessThan=1.
REQ-033 Result held with out_ready=0 for 5 cycles, new operands driven -> out_valid and flags unchanged, in_ready=0; out_ready=1 -> IDLE, next pair accepted following edge.
REQ-034 reset_n pulsed low during cycle 3 of an 8-cycle SCAN -> out_valid=0, flags 0 immediately; no result emitted; next pair compares correctly.
REQ-035 Sweep SLICE_W in {1, 8, 32} with random and corner operands (0, 0xFFFFFFFF, 0x7FFFFFFF, 0x80000000) -> flags match reference model; latency equals slices examined.

Source files
------------

// File: rtl/cmp_seq32.sv
// Multi-cycle 32-bit comparator that scans SLICE_W bits per cycle, most significant slice first.
// The scan stops at the first differing slice. Signed mode biases bit 31 so the scan is a plain magnitude compare.
module cmp_seq32 #(
  parameter int SLICE_W = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        cmp_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        isNotEqual,
  output logic        isLessThan
);

  localparam int NSLICE = 32 / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOPIDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state;
  state_t              stateNext;
  logic [31:0]         opA;
  logic [31:0]         opB;
  logic [IDXW-1:0]     sliceIdx;
  logic [5:0]          shiftAmt;
  logic [31:0]         shiftedA;
  logic [31:0]         shiftedB;
  logic [SLICE_W-1:0]  sliceA;
  logic [SLICE_W-1:0]  sliceB;
  logic                capture;
  logic                advance;
  logic                resolve;
  logic                resolveNeq;
  logic                resolveLt;

  // Right-align the current slice of each operand.
  assign shiftAmt = 6'(sliceIdx) * 6'(SLICE_W);
  assign shiftedA = opA >> shiftAmt;
  assign shiftedB = opB >> shiftAmt;
  assign sliceA   = shiftedA[SLICE_W-1:0];
  assign sliceB   = shiftedB[SLICE_W-1:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    stateNext  = state;
    capture    = 1'b0;
    advance    = 1'b0;
    resolve    = 1'b0;
    resolveNeq = 1'b0;
    resolveLt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        if (sliceA != sliceB) begin
          resolve    = 1'b1;
          resolveNeq = 1'b1;
          resolveLt  = (sliceA < sliceB);
          stateNext  = DONE;
        end else if (sliceIdx == '0) begin
          resolve   = 1'b1;
          stateNext = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Inverting bit 31 in signed mode maps two's-complement order onto unsigned order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opA        <= '0;
      opB        <= '0;
      sliceIdx   <= TOPIDX;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
    end else begin
      if (capture) begin
        opA      <= {data_operandA[31] ^ ~cmp_unsigned, data_operandA[30:0]};
        opB      <= {data_operandB[31] ^ ~cmp_unsigned, data_operandB[30:0]};
        sliceIdx <= TOPIDX;
      end else if (advance) begin
        sliceIdx <= sliceIdx - IDXW'(1);
      end
      if (resolve) begin
        isNotEqual <= resolveNeq;
        isLessThan <= resolveLt;
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq32.sv
// Bench for cmp_seq32: four instances (SLICE_W 1, 4, 8, 32) share operands and are checked every cycle
// against a transaction-level model that derives flags and latency from plain arithmetic.
module tb_cmp_seq32;

  localparam int NDUT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        cmpUns;
  logic        inValid  [NDUT];
  logic        outReady [NDUT];
  logic        inReady  [NDUT];
  logic        outValid [NDUT];
  logic        isNe     [NDUT];
  logic        isLt     [NDUT];

  int assertCount = 0;
  int failCount   = 0;
  int lat [NDUT];

  always #5 clock = ~clock;

  function automatic int swOf(input int g);
    case (g)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < NDUT; g++) begin : gDut
      cmp_seq32 #(.SLICE_W((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (inValid[g]),
        .in_ready      (inReady[g]),
        .data_operandA (dataA),
        .data_operandB (dataB),
        .cmp_unsigned  (cmpUns),
        .out_valid     (outValid[g]),
        .out_ready     (outReady[g]),
        .isNotEqual    (isNe[g]),
        .isLessThan    (isLt[g])
      );
    end
  endgenerate

  // Slices examined = slices from the top down to the highest differing bit (all slices when equal).
  function automatic int expLatency(input logic [31:0] a, input logic [31:0] b, input int sw);
    logic [31:0] x;
    int n;
    int p;
    x = a ^ b;
    n = 32 / sw;
    if (x == 0) return n;
    p = 0;
    for (int k = 0; k < 32; k++) if (x[k]) p = k;
    return n - (p / sw);
  endfunction

  function automatic logic expLess(input logic [31:0] a, input logic [31:0] b, input logic uns);
    if (uns) return a < b;
    return $signed(a) < $signed(b);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s dut%0d (SLICE_W=%0d): got %0d, expected %0d", name, idx, swOf(idx), act, exp);
    end
  endtask

  // Transaction model: a pending result matures after its latency, then is held until taken.
  logic mValid [NDUT];
  int   mCount [NDUT];
  logic mNeq   [NDUT];
  logic mLt    [NDUT];
  logic pNeq   [NDUT];
  logic pLt    [NDUT];

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!reset_n) begin
        mValid[i] <= 1'b0;
        mCount[i] <= 0;
        mNeq[i]   <= 1'b0;
        mLt[i]    <= 1'b0;
      end else if (mValid[i]) begin
        if (outReady[i]) mValid[i] <= 1'b0;
      end else if (mCount[i] > 0) begin
        mCount[i] <= mCount[i] - 1;
        if (mCount[i] == 1) begin
          mValid[i] <= 1'b1;
          mNeq[i]   <= pNeq[i];
          mLt[i]    <= pLt[i];
        end
      end else if (inValid[i]) begin
        pNeq[i]   <= (dataA != dataB);
        pLt[i]    <= expLess(dataA, dataB, cmpUns);
        mCount[i] <= expLatency(dataA, dataB, swOf(i));
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NDUT; i++) begin
      check("in_ready",   i, int'(inReady[i]),  int'(!mValid[i] && mCount[i] == 0));
      check("out_valid",  i, int'(outValid[i]), int'(mValid[i]));
      check("isNotEqual", i, int'(isNe[i]),     int'(mNeq[i]));
      check("isLessThan", i, int'(isLt[i]),     int'(mLt[i]));
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic uns, input int hold);
    bit done;
    int c;
    @(posedge clock); #2;
    dataA  = a;
    dataB  = b;
    cmpUns = uns;
    for (int i = 0; i < NDUT; i++) inValid[i] = 1'b1;
    @(posedge clock); #2;
    for (int i = 0; i < NDUT; i++) begin
      inValid[i] = 1'b0;
      lat[i]     = 0;
    end
    dataA  = $urandom;
    dataB  = $urandom;
    cmpUns = 1'($urandom);
    c    = 0;
    done = 1'b0;
    while (!done && c < 80) begin
      @(posedge clock); #2;
      c++;
      done = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (outValid[i] && lat[i] == 0) lat[i] = c;
        if (lat[i] == 0) done = 1'b0;
      end
    end
    if (!done) check("result_timeout", 0, c, -1);
    for (int i = 0; i < NDUT; i++) check("latency", i, lat[i], expLatency(a, b, swOf(i)));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #2;
      dataA = $urandom;
      dataB = $urandom;
      for (int i = 0; i < NDUT; i++) inValid[i] = 1'b1;
    end
    for (int i = 0; i < NDUT; i++) begin
      check("held_out_valid", i, int'(outValid[i]), 1);
      check("held_in_ready",  i, int'(inReady[i]),  0);
      inValid[i]  = 1'b0;
      outReady[i] = 1'b1;
    end
    @(posedge clock); #2;
    for (int i = 0; i < NDUT; i++) outReady[i] = 1'b0;
  endtask

  function automatic logic [31:0] pickOp();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset_n = 1'b0;
    dataA   = '0;
    dataB   = '0;
    cmpUns  = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #2;
    for (int i = 0; i < NDUT; i++) begin
      check("reset_out_valid", i, int'(outValid[i]), 0);
      check("reset_in_ready",  i, int'(inReady[i]),  1);
      check("reset_neq",       i, int'(isNe[i]),     0);
      check("reset_lt",        i, int'(isLt[i]),     0);
    end
    reset_n = 1'b1;

    // Equal operands scan every slice.
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    check("eq_lat_sw1",  0, lat[0], 32);
    check("eq_lat_sw4",  1, lat[1], 8);
    check("eq_lat_sw8",  2, lat[2], 4);
    check("eq_lat_sw32", 3, lat[3], 1);
    check("eq_neq", 1, int'(isNe[1]), 0);
    check("eq_lt",  1, int'(isLt[1]), 0);

    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    check("signed_lat", 1, lat[1], 1);
    check("signed_neq", 1, int'(isNe[1]), 1);
    check("signed_lt",  1, int'(isLt[1]), 1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    check("unsigned_neq", 1, int'(isNe[1]), 1);
    check("unsigned_lt",  1, int'(isLt[1]), 0);

    applyStimulus(32'h0000_0010, 32'h0000_0011, 1'b1, 5);
    check("last_slice_lat", 1, lat[1], 8);
    check("last_slice_neq", 1, int'(isNe[1]), 1);
    check("last_slice_lt",  1, int'(isLt[1]), 1);

    // Leave nonzero flags behind, then reset in the middle of an 8-slice scan.
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b1, 0);
    @(posedge clock); #2;
    dataA = 32'h1234_5678;
    dataB = 32'h1234_5678;
    for (int i = 0; i < NDUT; i++) inValid[i] = 1'b1;
    @(posedge clock); #2;
    for (int i = 0; i < NDUT; i++) inValid[i] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("midscan_out_valid", i, int'(outValid[i]), 0);
      check("midscan_neq",       i, int'(isNe[i]),     0);
      check("midscan_lt",        i, int'(isLt[i]),     0);
    end
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 0);
    check("post_reset_lat", 1, lat[1], 8);
    check("post_reset_neq", 1, int'(isNe[1]), 1);
    check("post_reset_lt",  1, int'(isLt[1]), 0);

    for (int n = 0; n < 200; n++) begin
      ra = pickOp();
      case ($urandom % 4)
        0:       rb = ra;
        1:       rb = ra ^ (32'h1 << ($urandom % 32));
        default: rb = pickOp();
      endcase
      applyStimulus(ra, rb, 1'($urandom), int'($urandom % 4));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
